// File: rtl/dmem_responder.sv
// Data-memory responder for the sequential Y86 core.
// Accepts one 8-byte read or write per handshake. The access is performed
// LATENCY cycles after the request is accepted, and the response is held
// until the initiator consumes it. Out-of-range addresses return err=1,
// rdata=0 and leave memory untouched.
module dmem_responder #(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW       = $clog2(MEM_BYTES);
  // Highest byte address at which a full 8-byte word still fits in memory.
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  // Latched request; pure data, so it carries no reset.
  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;

  logic [7:0]  mem [MEM_BYTES];

  logic        acc_fire;
  logic        acc_err;
  logic        mem_we;
  logic [63:0] rd_word;

  // Byte address of lane i of the word at address a (only used when in range).
  function automatic logic [AW-1:0] byte_idx(input logic [63:0] a, input int i);
    return a[AW-1:0] + AW'(i);
  endfunction

  // The access happens on the edge where the wait counter has run out.
  always_comb begin
    acc_fire = (state_q == S_WAIT) && (cnt_q == 4'd0);
    acc_err  = (addr_q > MAX_ADDR);
    // rst outranks the commit, so an abort on the commit edge writes nothing.
    mem_we   = acc_fire && write_q && !acc_err && !rst;
  end

  // Little-endian gather of the 8 bytes at the latched address.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++) begin
      rd_word[8*i +: 8] = mem[byte_idx(addr_q, i)];
    end
  end

  // Next-state and next-output logic for the request/wait/response sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = acc_err;
          resp_rdata_d = (acc_err || write_q) ? 64'd0 : rd_word;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = 64'd0;
          resp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b0;
        resp_rdata_d = 64'd0;
        resp_err_d   = 1'b0;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  // Control and response registers; rst wins over every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Request capture registers.
  always_ff @(posedge clk) begin
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Memory array write port; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        mem[byte_idx(addr_q, i)] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-written
// reset/backpressure sequences, and randomized traffic against a byte-array model.
module tb_dmem_responder;

  localparam int MEM_BYTES = 1024;
  localparam int LAT       = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mm [MEM_BYTES];

  dmem_responder #(.MEM_BYTES(MEM_BYTES), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
    end
  endtask

  // Reference: an access to an 8-byte word fits only if addr+8 <= MEM_BYTES.
  task automatic model_access(input logic w, input logic [63:0] a, input logic [63:0] d,
                              output logic [63:0] rd, output logic er);
    er = (a > 64'(MEM_BYTES - 8));
    rd = '0;
    if (!er) begin
      for (int i = 0; i < 8; i++) begin
        if (w) mm[int'(a) + i] = d[8*i +: 8];
        else   rd[8*i +: 8]    = mm[int'(a) + i];
      end
    end
  endtask

  // One full transaction; bp = cycles of held-off resp_ready with a competing request.
  task automatic txn(input logic w, input logic [63:0] a, input logic [63:0] d, input int bp,
                     output logic [63:0] rd, output logic er);
    int n;
    logic [63:0] rd0;
    logic        er0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    check("ready_low_after_accept", {63'd0, req_ready}, 64'd0);
    check("valid_low_after_accept", {63'd0, resp_valid}, 64'd0);
    // Scramble the request lines; the latched request must not change.
    req_write = ~w; req_addr = {$urandom, $urandom} & 64'h3FF; req_wdata = {$urandom, $urandom};
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("latency", 64'(n), 64'(LAT));
    rd0 = resp_rdata; er0 = resp_err;
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      check("bp_valid_held", {63'd0, resp_valid}, 64'd1);
      check("bp_rdata_stable", resp_rdata, rd0);
      check("bp_err_stable", {63'd0, resp_err}, {63'd0, er0});
      check("bp_no_accept", {63'd0, req_ready}, 64'd0);
    end
    req_valid = 1'b0;
    rd = resp_rdata; er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("resp_dropped", {63'd0, resp_valid}, 64'd0);
    check("rdata_cleared", resp_rdata, 64'd0);
    check("ready_back", {63'd0, req_ready}, 64'd1);
  endtask

  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [63:0] rd, mrd, d;
    logic        er, mer, w;
    logic [63:0] a;
    int          n;

    tbl[0]  = '{1'b1, 64'h10,  64'h0123456789ABCDEF, 64'h0, 1'b0};
    tbl[1]  = '{1'b0, 64'h10,  64'h0, 64'h0123456789ABCDEF, 1'b0};
    tbl[2]  = '{1'b1, 64'h3F8, 64'hCAFEF00DDEADBEEF, 64'h0, 1'b0};
    tbl[3]  = '{1'b0, 64'h3F8, 64'h0, 64'hCAFEF00DDEADBEEF, 1'b0};
    tbl[4]  = '{1'b0, 64'h3F9, 64'h0, 64'h0, 1'b1};
    tbl[5]  = '{1'b1, 64'hFFFFFFFFFFFFFFF8, 64'h5555555555555555, 64'h0, 1'b1};
    tbl[6]  = '{1'b1, 64'h3F9, 64'h1111111111111111, 64'h0, 1'b1};
    tbl[7]  = '{1'b0, 64'h3F8, 64'h0, 64'hCAFEF00DDEADBEEF, 1'b0};
    tbl[8]  = '{1'b1, 64'h28,  64'h00000000000000A5, 64'h0, 1'b0};
    tbl[9]  = '{1'b1, 64'h20,  64'h1122334455667788, 64'h0, 1'b0};
    tbl[10] = '{1'b0, 64'h21,  64'h0, 64'hA511223344556677, 1'b0};
    tbl[11] = '{1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0, 1'b1};
    tbl[12] = '{1'b0, 64'h400, 64'h0, 64'h0, 1'b1};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err", {63'd0, resp_err}, 64'd0);

    // Give every word a known value so model and DUT agree before any read.
    for (int i = 0; i < MEM_BYTES / 8; i++) begin
      d = {$urandom, $urandom};
      txn(1'b1, 64'(8 * i), d, 0, rd, er);
      model_access(1'b1, 64'(8 * i), d, mrd, mer);
      check("init_err", {63'd0, er}, 64'd0);
    end

    // Directed vectors with constant expectations.
    for (int i = 0; i < 13; i++) begin
      txn(tbl[i].w, tbl[i].a, tbl[i].d, i % 3, rd, er);
      model_access(tbl[i].w, tbl[i].a, tbl[i].d, mrd, mer);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_err", i), {63'd0, er}, {63'd0, tbl[i].exp_er});
    end

    // Long backpressure on a read.
    txn(1'b0, 64'h10, 64'h0, 5, rd, er);
    check("bp5_rdata", rd, 64'h0123456789ABCDEF);

    // rst asserted on the commit edge of a write: no write, outputs at reset values.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h30; req_wdata = 64'hAAAAAAAAAAAAAAAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_req_ready", {63'd0, req_ready}, 64'd1);
    check("abort_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("abort_resp_rdata", resp_rdata, 64'd0);
    check("abort_resp_err", {63'd0, resp_err}, 64'd0);
    @(posedge clk); #1;
    check("abort_still_idle", {63'd0, resp_valid}, 64'd0);
    txn(1'b0, 64'h30, 64'h0, 0, rd, er);
    model_access(1'b0, 64'h30, 64'h0, mrd, mer);
    check("abort_mem_kept", rd, mrd);

    // rst while the write response is pending: response dropped, write kept.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h38; req_wdata = 64'h5A5A0F0FC3C3E7E7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("resp_rst_latency", 64'(n), 64'(LAT));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("resp_rst_valid", {63'd0, resp_valid}, 64'd0);
    check("resp_rst_ready", {63'd0, req_ready}, 64'd1);
    model_access(1'b1, 64'h38, 64'h5A5A0F0FC3C3E7E7, mrd, mer);
    txn(1'b0, 64'h38, 64'h0, 0, rd, er);
    check("resp_rst_write_kept", rd, 64'h5A5A0F0FC3C3E7E7);

    // Randomized traffic against the model.
    for (int i = 0; i < 120; i++) begin
      w = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 64'($urandom_range(0, MEM_BYTES - 8));
        6:       a = 64'(MEM_BYTES - 8 + $urandom_range(0, 8));
        7:       a = {$urandom, $urandom};
        8:       a = 64'hFFFFFFFFFFFFFFF8 + 64'($urandom_range(0, 7));
        default: a = 64'(8 * $urandom_range(0, MEM_BYTES / 8 - 1));
      endcase
      txn(w, a, d, int'($urandom_range(0, 3)), rd, er);
      model_access(w, a, d, mrd, mer);
      check("rand_rdata", rd, mrd);
      check("rand_err", {63'd0, er}, {63'd0, mer});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
